// File: rtl/router_fsm.sv
// router_fsm: packet-sequencing controller for the 1x3 router.
// Walks each packet through header, payload, full-stall and parity phases and drives the datapath strobes.
`default_nettype none

module router_fsm (
  input  logic       clk,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg,
  output logic       busy,
  output logic       addr_err
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } state_t;

  state_t     state, state_nxt;
  logic [1:0] addr_q;
  logic       drop_q;
  logic       sel_empty;
  logic       sel_sreset;
  logic       hdr_accept;
  logic       hdr_bad;
  logic       hdr_empty;

  always_comb begin
    sel_empty  = 1'b0;
    sel_sreset = 1'b0;
    case (addr_q)
      2'd0: begin sel_empty = fifo_empty_0; sel_sreset = soft_reset_0; end
      2'd1: begin sel_empty = fifo_empty_1; sel_sreset = soft_reset_1; end
      2'd2: begin sel_empty = fifo_empty_2; sel_sreset = soft_reset_2; end
      default: begin sel_empty = 1'b0; sel_sreset = 1'b0; end
    endcase
  end

  // A header is only decoded when not discarding the tail of an address-3 packet.
  assign hdr_accept = (state == DECODE_ADDRESS) && pkt_valid && !drop_q;
  assign hdr_bad    = hdr_accept && (data_in == 2'd3);

  always_comb begin
    hdr_empty = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    if ((state != DECODE_ADDRESS) && sel_sreset) begin
      state_nxt = DECODE_ADDRESS;
    end else begin
      case (state)
        DECODE_ADDRESS: begin
          if (hdr_accept && !hdr_bad)
            state_nxt = hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
        LOAD_FIRST_DATA: state_nxt = LOAD_DATA;
        LOAD_DATA: begin
          if (fifo_full)       state_nxt = FIFO_FULL_STATE;
          else if (!pkt_valid) state_nxt = LOAD_PARITY;
        end
        FIFO_FULL_STATE: begin
          if (!fifo_full) state_nxt = LOAD_AFTER_FULL;
        end
        LOAD_AFTER_FULL: begin
          if (parity_done)        state_nxt = DECODE_ADDRESS;
          else if (low_pkt_valid) state_nxt = LOAD_PARITY;
          else                    state_nxt = LOAD_DATA;
        end
        LOAD_PARITY: state_nxt = CHECK_PARITY_ERROR;
        CHECK_PARITY_ERROR: state_nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
        WAIT_TILL_EMPTY: begin
          if (sel_empty) state_nxt = LOAD_FIRST_DATA;
        end
        default: state_nxt = DECODE_ADDRESS;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= DECODE_ADDRESS;
      addr_q   <= 2'd0;
      drop_q   <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      addr_err <= hdr_bad;
      if (hdr_accept)
        addr_q <= data_in;
      if (!pkt_valid)
        drop_q <= 1'b0;
      else if (hdr_bad)
        drop_q <= 1'b1;
    end
  end

  always_comb begin
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    busy          = 1'b0;
    case (state)
      DECODE_ADDRESS:     detect_add = 1'b1;
      LOAD_FIRST_DATA:    begin lfd_state = 1'b1; busy = 1'b1; end
      LOAD_DATA:          begin ld_state = 1'b1; write_enb_reg = 1'b1; end
      FIFO_FULL_STATE:    begin full_state = 1'b1; busy = 1'b1; end
      LOAD_AFTER_FULL:    begin laf_state = 1'b1; write_enb_reg = 1'b1; busy = 1'b1; end
      LOAD_PARITY:        begin write_enb_reg = 1'b1; busy = 1'b1; end
      CHECK_PARITY_ERROR: begin rst_int_reg = 1'b1; busy = 1'b1; end
      WAIT_TILL_EMPTY:    busy = 1'b1;
      default:            detect_add = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_router_fsm.sv
// tb_router_fsm: directed scenarios plus random traffic, checked against a phase-level reference model.
`default_nettype none

module tb_router_fsm;

  logic       clk = 1'b0;
  logic       resetn, pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic       soft_reset_0, soft_reset_1, soft_reset_2;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg, busy, addr_err;
  logic [8:0] obs;

  int n_assert = 0;
  int n_fail   = 0;

  router_fsm dut (
    .clk(clk), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
    .rst_int_reg(rst_int_reg), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  assign obs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                write_enb_reg, rst_int_reg, busy, addr_err};

  // Reference: packet phase, remembered destination, discard flag for address-3 packets.
  typedef enum int {P_DA, P_LFD, P_LD, P_FFS, P_LAF, P_LP, P_CPE, P_WTE} phase_t;
  phase_t m_ph;
  int     m_addr;
  bit     m_drop, m_err;

  function automatic bit empty_of(int a);
    if (a == 0) return fifo_empty_0;
    if (a == 1) return fifo_empty_1;
    if (a == 2) return fifo_empty_2;
    return 1'b0;
  endfunction

  function automatic bit sreset_of(int a);
    if (a == 0) return soft_reset_0;
    if (a == 1) return soft_reset_1;
    if (a == 2) return soft_reset_2;
    return 1'b0;
  endfunction

  function automatic logic [8:0] expected();
    logic [8:0] e;
    e[8] = (m_ph == P_DA);
    e[7] = (m_ph == P_LFD);
    e[6] = (m_ph == P_LD);
    e[5] = (m_ph == P_LAF);
    e[4] = (m_ph == P_FFS);
    e[3] = (m_ph == P_LD) || (m_ph == P_LAF) || (m_ph == P_LP);
    e[2] = (m_ph == P_CPE);
    e[1] = !((m_ph == P_DA) || (m_ph == P_LD));
    e[0] = m_err;
    return e;
  endfunction

  task automatic model_reset();
    m_ph = P_DA; m_addr = 0; m_drop = 1'b0; m_err = 1'b0;
  endtask

  task automatic check(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // One clock: predict from pre-edge inputs, then compare every output after the edge.
  task automatic tick(string tag);
    phase_t nx;
    bit     hdr, bad;
    int     a_in;
    a_in = int'(data_in);
    hdr  = (m_ph == P_DA) && pkt_valid && !m_drop;
    bad  = hdr && (a_in == 3);
    nx   = m_ph;
    if (m_ph != P_DA && sreset_of(m_addr)) nx = P_DA;
    else case (m_ph)
      P_DA:  if (hdr && !bad) nx = empty_of(a_in) ? P_LFD : P_WTE;
      P_LFD: nx = P_LD;
      P_LD:  nx = fifo_full ? P_FFS : (!pkt_valid ? P_LP : P_LD);
      P_FFS: nx = fifo_full ? P_FFS : P_LAF;
      P_LAF: nx = parity_done ? P_DA : (low_pkt_valid ? P_LP : P_LD);
      P_LP:  nx = P_CPE;
      P_CPE: nx = fifo_full ? P_FFS : P_DA;
      P_WTE: nx = empty_of(m_addr) ? P_LFD : P_WTE;
      default: nx = P_DA;
    endcase
    @(posedge clk); #1;
    m_err = bad;
    if (hdr) m_addr = a_in;
    if (!pkt_valid) m_drop = 1'b0;
    else if (bad) m_drop = 1'b1;
    m_ph = nx;
    check(tag, 32'(obs), 32'(expected()));
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
  endtask

  initial begin
    int we_cnt, rst_cnt, ld_cnt, busy_ld, cnt;
    resetn = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check("reset_outputs", 32'(obs), 32'h100);
    @(posedge clk); #1;
    resetn = 1'b1;
    tick("idle");

    // Address 1, four LD cycles then parity.
    pkt_valid = 1; data_in = 2'd1;
    tick("t1_header");
    we_cnt = 0; rst_cnt = 0; ld_cnt = 0; busy_ld = 0;
    for (int i = 0; i < 7; i++) begin
      pkt_valid = (i < 4);
      data_in   = 2'($urandom);
      tick("t1_pkt");
      we_cnt  += int'(write_enb_reg);
      rst_cnt += int'(rst_int_reg);
      ld_cnt  += int'(ld_state);
      busy_ld += int'(ld_state & busy);
    end
    check("t1_write_cycles", we_cnt, 5);
    check("t1_rst_int_cycles", rst_cnt, 1);
    check("t1_ld_cycles", ld_cnt, 4);
    check("t1_busy_in_ld", busy_ld, 0);
    check("t1_back_to_da", 32'(detect_add), 1);

    // Address 0 while FIFO 0 is non-empty for 10 cycles.
    pkt_valid = 1; data_in = 2'd0; fifo_empty_0 = 0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick("t2_wait");
      cnt += int'(busy);
    end
    check("t2_busy_in_wte", cnt, 10);
    fifo_empty_0 = 1;
    tick("t2_leave_wte");
    check("t2_lfd_after_empty", 32'(lfd_state), 1);
    tick("t2_ld");
    pkt_valid = 0;
    tick("t2_lp"); tick("t2_cpe"); tick("t2_da");

    // Full stall for 3 cycles mid-LD.
    pkt_valid = 1; data_in = 2'd1;
    tick("t3_header"); tick("t3_lfd"); tick("t3_ld");
    fifo_full = 1;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick("t3_full");
      cnt += int'(full_state);
    end
    check("t3_ffs_cycles", cnt, 3);
    fifo_full = 0;
    tick("t3_laf");
    check("t3_in_laf", 32'(laf_state), 1);
    tick("t3_back_ld");
    check("t3_back_in_ld", 32'(ld_state), 1);
    pkt_valid = 0;
    tick("t3_lp"); tick("t3_cpe"); tick("t3_da");

    // Address 2 with soft resets: FIFO 0 ignored, FIFO 2 aborts.
    pkt_valid = 1; data_in = 2'd2;
    tick("t4_header"); tick("t4_lfd");
    soft_reset_0 = 1;
    tick("t4_sr0_ignored");
    check("t4_still_ld", 32'(ld_state), 1);
    soft_reset_0 = 0; soft_reset_2 = 1;
    tick("t4_sr2_abort");
    check("t4_detect_add", 32'(detect_add), 1);
    soft_reset_2 = 0; pkt_valid = 0;
    tick("t4_idle");

    // Address 3: stay in DA, one-cycle addr_err, trailing bytes ignored.
    pkt_valid = 1; data_in = 2'd3;
    we_cnt = 0; cnt = 0;
    tick("t5_header");
    check("t5_addr_err_high", 32'(addr_err), 1);
    data_in = 2'd0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) pkt_valid = 0;
      tick("t5_tail");
      we_cnt += int'(write_enb_reg);
      cnt    += int'(addr_err);
    end
    check("t5_addr_err_pulse", cnt, 0);
    check("t5_no_write", we_cnt, 0);

    // Asynchronous reset while stalled on full.
    pkt_valid = 1; data_in = 2'd1;
    tick("t6_header"); tick("t6_lfd");
    fifo_full = 1;
    tick("t6_ffs");
    #2 resetn = 1'b0;
    #1 check("t6_async_reset", 32'(obs), 32'h100);
    model_reset();
    idle_inputs();
    tick("t6_hold_reset");
    resetn = 1'b1;
    tick("t6_release");

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      pkt_valid     = ($urandom_range(0, 9) < 7);
      data_in       = 2'($urandom);
      fifo_full     = ($urandom_range(0, 4) == 0);
      fifo_empty_0  = ($urandom_range(0, 2) != 0);
      fifo_empty_1  = ($urandom_range(0, 2) != 0);
      fifo_empty_2  = ($urandom_range(0, 2) != 0);
      soft_reset_0  = ($urandom_range(0, 29) == 0);
      soft_reset_1  = ($urandom_range(0, 29) == 0);
      soft_reset_2  = ($urandom_range(0, 29) == 0);
      parity_done   = ($urandom_range(0, 3) == 0);
      low_pkt_valid = ($urandom_range(0, 3) == 0);
      tick("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
